fifo_to_video_ctrl: RTL and testbench

Read-side counterpart of the video-to-DDR write path. Pops 128-bit words from the FWFT read FIFO filled by the AXI read-burst engine, unpacks each into four 24-bit pixels, and drives them out aligned with the incoming display timing. It also issues one line-burst request per active line to the AXI read master, with one line of lookahead.

---
 rtl/fifo_to_video_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fifo_to_video_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_video_ctrl.sv
// fifo_to_video_ctrl: unpacks 128-bit FWFT FIFO words into 24-bit pixels
// aligned with the incoming display timing. It also requests one AXI read
// burst per active line, one line ahead of the display.
module fifo_to_video_ctrl #(
  parameter int          V_ACTIVE        = 1080,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic         video_clk,
  input  logic         video_rst,
  input  logic         video_vs_in,
  input  logic         video_hs_in,
  input  logic         video_de_in,
  input  logic [127:0] fifo_data_in,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic         video_vs_out,
  output logic         video_hs_out,
  output logic         video_de_out,
  output logic [23:0]  video_data_out,
  output logic         AXI_FULL_BURST_VALID,
  input  logic         AXI_FULL_BURST_READY,
  output logic         frame_start,
  output logic         underflow
);

  localparam int              CW     = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0]   C_VMAX = CW'(V_ACTIVE);
  localparam logic [0:0]      S_IDLE = 1'b0;
  localparam logic [0:0]      S_REQ  = 1'b1;

  // Registered timing; the one-cycle-delayed vs/de copies double as the
  // edge-detect history, so video_vs_out/video_de_out are those registers.
  logic          r_vs_d;
  logic          r_de_d;
  logic          r_hs_out;
  logic [23:0]   r_data;
  logic          r_frame_start;
  logic          r_underflow;
  logic [1:0]    r_pix_cnt;
  logic [CW-1:0] r_req_cnt;
  logic          r_pending;
  logic [0:0]    r_state;

  logic          w_vs_rise;
  logic          w_de_fall;
  logic          w_line_trig;
  logic          w_trig;
  logic [23:0]   w_pixel;
  logic [0:0]    w_state_nxt;
  logic          w_pending_nxt;
  logic          w_unused_pad;

  assign w_vs_rise   = video_vs_in & ~r_vs_d;
  assign w_de_fall   = ~video_de_in & r_de_d;
  assign w_line_trig = w_de_fall & (r_req_cnt < C_VMAX);
  assign w_trig      = w_vs_rise | w_line_trig;

  // Padding bytes of each word carry no pixel data.
  assign w_unused_pad = ^{fifo_data_in[127:120], fifo_data_in[95:88],
                          fifo_data_in[63:56],   fifo_data_in[31:24]};

  assign fifo_rd_en           = video_de_in & (r_pix_cnt == 2'd3) & ~fifo_empty;
  assign AXI_FULL_BURST_VALID = (r_state == S_REQ);
  assign video_vs_out         = r_vs_d;
  assign video_hs_out         = r_hs_out;
  assign video_de_out         = r_de_d;
  assign video_data_out       = r_data;
  assign frame_start          = r_frame_start;
  assign underflow            = r_underflow;

  // Select the current pixel slice of the FIFO head word, oldest first.
  always_comb begin
    w_pixel = fifo_data_in[23:0];
    case (r_pix_cnt)
      2'd0:    w_pixel = fifo_data_in[119:96];
      2'd1:    w_pixel = fifo_data_in[87:64];
      2'd2:    w_pixel = fifo_data_in[55:32];
      default: w_pixel = fifo_data_in[23:0];
    endcase
  end

  // Video path: delayed timing, pixel data, frame pulse and sticky underflow.
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      r_vs_d        <= 1'b0;
      r_de_d        <= 1'b0;
      r_hs_out      <= 1'b0;
      r_data        <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_vs_d        <= video_vs_in;
      r_de_d        <= video_de_in;
      r_hs_out      <= video_hs_in;
      r_frame_start <= w_vs_rise;
      if (!video_de_in)
        r_data <= '0;
      else if (fifo_empty)
        r_data <= UNDERFLOW_COLOR;
      else
        r_data <= w_pixel;
      if (video_de_in && fifo_empty)
        r_underflow <= 1'b1;
    end
  end

  // Pixel slice counter: restarts each frame, advances on every active pixel.
  always_ff @(posedge video_clk) begin
    if (video_rst)
      r_pix_cnt <= '0;
    else if (w_vs_rise)
      r_pix_cnt <= '0;
    else if (video_de_in)
      r_pix_cnt <= r_pix_cnt + 2'd1;
  end

  // Line request counter: vs_rise requests line 0, saturates at V_ACTIVE.
  always_ff @(posedge video_clk) begin
    if (video_rst)
      r_req_cnt <= '0;
    else if (w_vs_rise)
      r_req_cnt <= CW'(1);
    else if (w_line_trig)
      r_req_cnt <= r_req_cnt + CW'(1);
  end

  // Request FSM next state; a trigger during a handshake is served directly,
  // otherwise it is parked in the single pending slot.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_trig)
          w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (AXI_FULL_BURST_READY) begin
          w_state_nxt   = (r_pending | w_trig) ? S_REQ : S_IDLE;
          w_pending_nxt = r_pending & w_trig;
        end else begin
          w_pending_nxt = r_pending | w_trig;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_to_video_ctrl.sv
// Directed bench for fifo_to_video_ctrl with a small FWFT FIFO model.
module tb_fifo_to_video_ctrl;

  localparam int          VA = 4;
  localparam logic [23:0] UF = 24'h5A5A5A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vs = 1'b0, hs = 1'b0, de = 1'b0, ready = 1'b1;
  logic [127:0] fdata;
  logic         fempty;
  logic         rd_en, vs_o, hs_o, de_o, valid, fs, uf;
  logic [23:0]  dout;

  logic [127:0] fmem [256];
  int unsigned  wp = 0;
  int unsigned  rp = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fempty = (rp == wp);
  assign fdata  = fmem[rp[7:0]];

  fifo_to_video_ctrl #(.V_ACTIVE(VA), .UNDERFLOW_COLOR(UF)) dut (
    .video_clk(clk), .video_rst(rst),
    .video_vs_in(vs), .video_hs_in(hs), .video_de_in(de),
    .fifo_data_in(fdata), .fifo_empty(fempty), .fifo_rd_en(rd_en),
    .video_vs_out(vs_o), .video_hs_out(hs_o), .video_de_out(de_o),
    .video_data_out(dout),
    .AXI_FULL_BURST_VALID(valid), .AXI_FULL_BURST_READY(ready),
    .frame_start(fs), .underflow(uf)
  );

  // FIFO pop
  always @(posedge clk) if (rd_en && !fempty) rp <= rp + 1;

  // Monitor: counters sampled mid-cycle
  int unsigned rd_cnt = 0, rd_empty_err = 0, hs_cnt = 0, vrise_cnt = 0, vfall_cnt = 0;
  int unsigned fs_cnt = 0, lat_err = 0, vr_err = 0, fs_err = 0, out_n = 0;
  logic [23:0] out_mem [1024];
  logic valid_l = 1'b0, vs_l = 1'b0, de_l = 1'b0, trig_l = 1'b0, rst_l = 1'b1, vs_o_l = 1'b0;
  logic [2:0] vhd_l = 3'b000;

  always @(negedge clk) begin
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en && fempty) rd_empty_err <= rd_empty_err + 1;
    if (valid && ready) hs_cnt <= hs_cnt + 1;
    if (valid && !valid_l) vrise_cnt <= vrise_cnt + 1;
    if (valid && !valid_l && !trig_l) vr_err <= vr_err + 1;
    if (!valid && valid_l) vfall_cnt <= vfall_cnt + 1;
    if (fs) fs_cnt <= fs_cnt + 1;
    if (!rst_l) begin
      if ({vs_o, hs_o, de_o} !== vhd_l) lat_err <= lat_err + 1;
      if (fs !== (vs_o & !vs_o_l)) fs_err <= fs_err + 1;
    end
    if (de_o) begin
      out_mem[out_n[9:0]] <= dout;
      out_n <= out_n + 1;
    end
    valid_l <= valid;
    vs_l    <= vs;
    de_l    <= de;
    trig_l  <= (vs & !vs_l) | (!de & de_l);
    vhd_l   <= {vs, hs, de};
    rst_l   <= rst;
    vs_o_l  <= vs_o;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0;
    cycles(2);
    rst = 1'b0;
    cyc();
  endtask

  task automatic push_px(input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input logic [23:0] d);
    fmem[wp[7:0]] = {8'hff, a, 8'hff, b, 8'hff, c, 8'hff, d};
    wp = wp + 1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1; cycles(2);
    vs = 1'b0; cycles(2);
  endtask

  task automatic line(input int n);
    hs = 1'b1; cyc();
    hs = 1'b0; cycles(2);
    de = 1'b1; cycles(n);
    de = 1'b0; cycles(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    cycles(3);
    n_vec++; if ({vs_o, hs_o, de_o, fs, uf, valid, rd_en} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000000", {vs_o, hs_o, de_o, fs, uf, valid, rd_en});
    end
    n_vec++; if (dout !== 24'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 000000", dout);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_stream();
    int unsigned s_out, s_rd, s_hs, s_vr, s_fs, s_lat, s_vre, s_fse, s_re;
    logic [23:0] e;
    do_reset();
    ready = 1'b1;
    for (int w = 0; w < 8; w++)
      push_px(24'(4*w+1), 24'(4*w+2), 24'(4*w+3), 24'(4*w+4));
    s_out = out_n; s_rd = rd_cnt; s_hs = hs_cnt; s_vr = vrise_cnt; s_fs = fs_cnt;
    s_lat = lat_err; s_vre = vr_err; s_fse = fs_err; s_re = rd_empty_err;
    vs_pulse();
    repeat (4) line(8);
    cycles(4);
    n_vec++; if (out_n - s_out != 32) begin
      n_err++; $display("FAIL stream_count: got %0d expected 32", out_n - s_out);
    end
    for (int i = 0; i < 32; i++) begin
      e = 24'(i + 1);
      n_vec++; if (out_mem[(s_out + i) % 1024] !== e) begin
        n_err++; $display("FAIL stream_px[%0d]: got %h expected %h", i, out_mem[(s_out + i) % 1024], e);
      end
    end
    n_vec++; if (rd_cnt - s_rd != 8) begin
      n_err++; $display("FAIL stream_pops: got %0d expected 8", rd_cnt - s_rd);
    end
    n_vec++; if (hs_cnt - s_hs != 4) begin
      n_err++; $display("FAIL stream_handshakes: got %0d expected 4", hs_cnt - s_hs);
    end
    n_vec++; if (vrise_cnt - s_vr != 4) begin
      n_err++; $display("FAIL stream_valid_pulses: got %0d expected 4", vrise_cnt - s_vr);
    end
    n_vec++; if (fs_cnt - s_fs != 1) begin
      n_err++; $display("FAIL stream_frame_start: got %0d expected 1", fs_cnt - s_fs);
    end
    n_vec++; if (lat_err - s_lat != 0) begin
      n_err++; $display("FAIL stream_latency: got %0d bad cycles expected 0", lat_err - s_lat);
    end
    n_vec++; if (vr_err - s_vre != 0) begin
      n_err++; $display("FAIL stream_valid_timing: got %0d untriggered rises expected 0", vr_err - s_vre);
    end
    n_vec++; if (fs_err - s_fse != 0) begin
      n_err++; $display("FAIL stream_fs_align: got %0d bad cycles expected 0", fs_err - s_fse);
    end
    n_vec++; if (uf !== 1'b0 || rd_empty_err != s_re) begin
      n_err++; $display("FAIL stream_underflow: got uf=%b empty_pops=%0d expected 0", uf, rd_empty_err - s_re);
    end
  endtask

  task automatic test_backpressure();
    int unsigned s_hs, s_vr, s_vf;
    do_reset();
    ready = 1'b0;
    for (int w = 0; w < 8; w++)
      push_px(24'h100 + 24'(w), 24'h200, 24'h300, 24'h400);
    s_hs = hs_cnt; s_vr = vrise_cnt; s_vf = vfall_cnt;
    vs_pulse();
    repeat (3) line(8);
    n_vec++; if (valid !== 1'b1 || vfall_cnt != s_vf) begin
      n_err++; $display("FAIL bp_valid_held: got valid=%b falls=%0d expected 1 and 0", valid, vfall_cnt - s_vf);
    end
    ready = 1'b1;
    cycles(4);
    n_vec++; if (hs_cnt - s_hs != 2) begin
      n_err++; $display("FAIL bp_handshakes: got %0d expected 2", hs_cnt - s_hs);
    end
    n_vec++; if (vrise_cnt - s_vr != 1 || vfall_cnt - s_vf != 1) begin
      n_err++; $display("FAIL bp_back_to_back: got rises=%0d falls=%0d expected 1 and 1", vrise_cnt - s_vr, vfall_cnt - s_vf);
    end
    line(8);
    cycles(3);
    n_vec++; if (hs_cnt - s_hs != 2) begin
      n_err++; $display("FAIL bp_saturate: got %0d expected 2", hs_cnt - s_hs);
    end
  endtask

  task automatic test_underflow();
    int unsigned s_out, s_rd, s_re;
    do_reset();
    ready = 1'b1;
    push_px(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    s_out = out_n; s_rd = rd_cnt; s_re = rd_empty_err;
    vs_pulse();
    n_vec++; if (uf !== 1'b0) begin
      n_err++; $display("FAIL uf_before: got %b expected 0", uf);
    end
    line(8);
    n_vec++; if (out_n - s_out != 8) begin
      n_err++; $display("FAIL uf_count: got %0d expected 8", out_n - s_out);
    end
    n_vec++; if (out_mem[s_out % 1024] !== 24'h111111 || out_mem[(s_out + 3) % 1024] !== 24'h444444) begin
      n_err++; $display("FAIL uf_valid_px: got %h %h expected 111111 444444", out_mem[s_out % 1024], out_mem[(s_out + 3) % 1024]);
    end
    for (int i = 4; i < 8; i++) begin
      n_vec++; if (out_mem[(s_out + i) % 1024] !== UF) begin
        n_err++; $display("FAIL uf_color[%0d]: got %h expected %h", i, out_mem[(s_out + i) % 1024], UF);
      end
    end
    n_vec++; if (uf !== 1'b1) begin
      n_err++; $display("FAIL uf_flag: got %b expected 1", uf);
    end
    line(8);
    n_vec++; if (out_mem[(s_out + 8) % 1024] !== UF || out_mem[(s_out + 15) % 1024] !== UF) begin
      n_err++; $display("FAIL uf_line2: got %h %h expected %h", out_mem[(s_out + 8) % 1024], out_mem[(s_out + 15) % 1024], UF);
    end
    n_vec++; if (uf !== 1'b1) begin
      n_err++; $display("FAIL uf_sticky: got %b expected 1", uf);
    end
    n_vec++; if (rd_cnt - s_rd != 1 || rd_empty_err != s_re) begin
      n_err++; $display("FAIL uf_pops: got pops=%0d empty_pops=%0d expected 1 and 0", rd_cnt - s_rd, rd_empty_err - s_re);
    end
  endtask

  task automatic test_vs_collide();
    int unsigned s_hs, s_vr, s_vf, s_fs;
    do_reset();
    ready = 1'b0;
    for (int w = 0; w < 10; w++)
      push_px(24'h500 + 24'(w), 24'h600, 24'h700, 24'h800);
    s_hs = hs_cnt; s_vr = vrise_cnt; s_vf = vfall_cnt; s_fs = fs_cnt;
    vs_pulse();
    hs = 1'b1; cyc();
    hs = 1'b0; cycles(2);
    de = 1'b1; cycles(8);
    de = 1'b0; vs = 1'b1; cycles(2);
    vs = 1'b0; cycles(2);
    n_vec++; if (valid !== 1'b1 || vfall_cnt != s_vf || hs_cnt != s_hs) begin
      n_err++; $display("FAIL col_hold: got valid=%b falls=%0d hs=%0d expected 1 0 0", valid, vfall_cnt - s_vf, hs_cnt - s_hs);
    end
    n_vec++; if (fs_cnt - s_fs != 2) begin
      n_err++; $display("FAIL col_frame_start: got %0d expected 2", fs_cnt - s_fs);
    end
    ready = 1'b1;
    cycles(4);
    n_vec++; if (hs_cnt - s_hs != 2 || vrise_cnt - s_vr != 1 || vfall_cnt - s_vf != 1) begin
      n_err++; $display("FAIL col_extra_hs: got hs=%0d rises=%0d falls=%0d expected 2 1 1", hs_cnt - s_hs, vrise_cnt - s_vr, vfall_cnt - s_vf);
    end
    s_hs = hs_cnt;
    repeat (4) line(8);
    n_vec++; if (hs_cnt - s_hs != 3) begin
      n_err++; $display("FAIL col_req_cnt: got %0d line requests expected 3", hs_cnt - s_hs);
    end
  endtask

  task automatic test_reset_midline();
    int unsigned s_out, s_rd;
    do_reset();
    ready = 1'b0;
    push_px(24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004);
    push_px(24'hB00001, 24'hB00002, 24'hB00003, 24'hB00004);
    vs_pulse();
    n_vec++; if (valid !== 1'b1) begin
      n_err++; $display("FAIL rstm_valid_before: got %b expected 1", valid);
    end
    hs = 1'b1; cyc();
    hs = 1'b0; de = 1'b1; cycles(2);
    rst = 1'b1; cyc();
    n_vec++; if ({vs_o, hs_o, de_o, fs, uf, valid, rd_en} !== 7'b0 || dout !== 24'h0) begin
      n_err++; $display("FAIL rstm_outputs: got %b data %h expected 0", {vs_o, hs_o, de_o, fs, uf, valid, rd_en}, dout);
    end
    s_out = out_n; s_rd = rd_cnt;
    rst = 1'b0; de = 1'b0; cycles(2);
    de = 1'b1; cycles(4);
    de = 1'b0; cycles(2);
    n_vec++; if (out_n - s_out != 4) begin
      n_err++; $display("FAIL rstm_count: got %0d expected 4", out_n - s_out);
    end
    n_vec++; if (out_mem[s_out % 1024] !== 24'hA00001 || out_mem[(s_out + 3) % 1024] !== 24'hA00004) begin
      n_err++; $display("FAIL rstm_first_slice: got %h %h expected a00001 a00004", out_mem[s_out % 1024], out_mem[(s_out + 3) % 1024]);
    end
    n_vec++; if (rd_cnt - s_rd != 1) begin
      n_err++; $display("FAIL rstm_pops: got %0d expected 1", rd_cnt - s_rd);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_underflow();
    test_vs_collide();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
